// File: rtl/note_player.sv
// -----------------------------------------------------------------------------
// note_player
//
// Plays one note at a time for the song reader. A note index and a length in
// beats are latched on load_new_note; the note's phase step is fetched from an
// internal frequency ROM and a phase accumulator (10.12 fixed point) is
// advanced on every sample tick. The accumulator is shaped into a triangle
// wave. After the requested number of beats the block pulses done_with_note.
//
// Ports
//   clk                  : sole clock, rising edge
//   reset                : synchronous, active-high
//   play_enable          : 1 = running, 0 = paused (beats/samples frozen)
//   note_to_load[5:0]    : note index, 0 = rest (silence)
//   duration_to_load[5:0]: note length in beats
//   load_new_note        : one-cycle pulse, note/duration valid
//   beat                 : one-cycle tick, 48 per second
//   generate_next_sample : one-cycle sample-rate tick
//   done_with_note       : one-cycle pulse, note finished
//   sample_out[15:0]     : signed two's complement sample
//   new_sample_ready     : one-cycle pulse, sample_out updated this cycle
//   dbg_state_o[1:0]     : current FSM state (IDLE=0, LOAD=1, PLAYING=2, DONE=3)
//
// Handshake: all inputs and outputs named "pulse"/"tick" are single-cycle
// strobes with no back-pressure. load_new_note is only taken in IDLE and DONE;
// a pulse arriving in LOAD or PLAYING is dropped, so the song reader must wait
// for done_with_note before offering the next note.
// -----------------------------------------------------------------------------
module note_player #(
    parameter int PHASE_W = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play_enable,
    input  logic [5:0]  note_to_load,
    input  logic [5:0]  duration_to_load,
    input  logic        load_new_note,
    input  logic        beat,
    input  logic        generate_next_sample,
    output logic        done_with_note,
    output logic [15:0] sample_out,
    output logic        new_sample_ready,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_PLAYING = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [5:0]           note_q, note_d;
    logic [5:0]           dur_q, dur_d;
    logic [PHASE_W-1:0]   step_q, step_d;
    logic [5:0]           beats_q, beats_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [15:0]          sample_q, sample_d;
    logic                 ready_q, ready_d;

    // ------------------------------------------------------------------------
    // Frequency ROM. Equal-tempered scale starting at note 1 = 55 Hz with a
    // 48 kHz sample rate: step = f * 2^22 / 48000. One octave of base steps is
    // stored; each further octave doubles the step, so octave k is base << k.
    // ------------------------------------------------------------------------
    logic [5:0]           note_m1;
    logic [3:0]           semi;
    logic [2:0]           octave;
    logic [13:0]          base_step;
    logic [PHASE_W-1:0]   rom_step;

    always_comb begin
        note_m1 = note_q - 6'd1;
        semi    = 4'(note_m1 % 6'd12);
        octave  = 3'(note_m1 / 6'd12);
        case (semi)
            4'd0:    base_step = 14'd4806;
            4'd1:    base_step = 14'd5092;
            4'd2:    base_step = 14'd5395;
            4'd3:    base_step = 14'd5715;
            4'd4:    base_step = 14'd6055;
            4'd5:    base_step = 14'd6415;
            4'd6:    base_step = 14'd6797;
            4'd7:    base_step = 14'd7201;
            4'd8:    base_step = 14'd7629;
            4'd9:    base_step = 14'd8083;
            4'd10:   base_step = 14'd8563;
            4'd11:   base_step = 14'd9072;
            default: base_step = 14'd0;
        endcase
        if (note_q == 6'd0) begin
            rom_step = '0;
        end else begin
            rom_step = PHASE_W'(base_step) << octave;
        end
    end

    // ------------------------------------------------------------------------
    // Triangle shaper applied to the advanced phase, so the sample emitted for
    // a tick reflects the phase after that tick. Folding the top 16 phase bits
    // at the half-way point gives a 15-bit ramp up then down; doubling and
    // re-centring maps it onto -32768..32766. Overflow of the add is the
    // intended modular wrap.
    // ------------------------------------------------------------------------
    logic [PHASE_W-1:0]   phase_next;
    logic [15:0]          wave_p;
    logic [14:0]          wave_t;
    logic [15:0]          wave_s;

    always_comb begin
        phase_next = phase_q + step_q;
        wave_p     = phase_next[PHASE_W-1 -: 16];
        wave_t     = wave_p[15] ? ~wave_p[14:0] : wave_p[14:0];
        wave_s     = {wave_t, 1'b0} - 16'h8000;
    end

    // ------------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------------
    logic tick_ok;
    logic beat_ok;

    always_comb begin
        state_d        = state_q;
        note_d         = note_q;
        dur_d          = dur_q;
        step_d         = step_q;
        beats_d        = beats_q;
        phase_d        = phase_q;
        sample_d       = sample_q;
        ready_d        = 1'b0;
        done_with_note = 1'b0;
        tick_ok        = play_enable & generate_next_sample;
        beat_ok        = play_enable & beat;

        case (state_q)
            S_IDLE: begin
                if (load_new_note) begin
                    note_d  = note_to_load;
                    dur_d   = duration_to_load;
                    state_d = S_LOAD;
                end
            end

            // Single cycle: registers the ROM read for the latched note and
            // arms the beat counter. A zero-length note skips playback.
            S_LOAD: begin
                step_d  = rom_step;
                beats_d = dur_q;
                phase_d = '0;
                state_d = (dur_q == 6'd0) ? S_DONE : S_PLAYING;
            end

            // Beat and sample ticks are independent, so a final beat that
            // coincides with a sample tick still produces that sample.
            S_PLAYING: begin
                if (beat_ok) begin
                    beats_d = beats_q - 6'd1;
                    if (beats_q == 6'd1) begin
                        state_d = S_DONE;
                    end
                end
                if (tick_ok) begin
                    ready_d = 1'b1;
                    if (note_q == 6'd0) begin
                        sample_d = 16'd0;
                    end else begin
                        phase_d  = phase_next;
                        sample_d = wave_s;
                    end
                end
            end

            // Done pulses regardless; a new note offered here goes straight
            // to LOAD so back-to-back notes lose no cycle in IDLE.
            S_DONE: begin
                done_with_note = 1'b1;
                if (load_new_note) begin
                    note_d  = note_to_load;
                    dur_d   = duration_to_load;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            note_q   <= '0;
            dur_q    <= '0;
            step_q   <= '0;
            beats_q  <= '0;
            phase_q  <= '0;
            sample_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            dur_q    <= dur_d;
            step_q   <= step_d;
            beats_q  <= beats_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
            ready_q  <= ready_d;
        end
    end

    assign sample_out       = sample_q;
    assign new_sample_ready = ready_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;

  localparam int PHASE_W = 22;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        play_enable;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        load_new_note;
  logic        beat;
  logic        generate_next_sample;
  logic        done_with_note;
  logic [15:0] sample_out;
  logic        new_sample_ready;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] last_sample;

  note_player #(.PHASE_W(PHASE_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .load_new_note        (load_new_note),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .done_with_note       (done_with_note),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready),
    .dbg_state_o          (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Step table: equal temperament from 55 Hz, step = f * 2^22 / 48000.
  function automatic longint model_step(input int n);
    int base[12] = '{4806, 5092, 5395, 5715, 6055, 6415,
                     6797, 7201, 7629, 8083, 8563, 9072};
    longint mult;
    if (n == 0) return 0;
    mult = 1;
    for (int k = 0; k < (n - 1) / 12; k++) mult = mult * 2;
    return longint'(base[(n - 1) % 12]) * mult;
  endfunction

  // Triangle from the top 16 bits of a 22-bit phase.
  function automatic logic [15:0] model_wave(input longint ph);
    longint p;
    longint t;
    longint s;
    p = (ph / 64) % 65536;
    t = (p >= 32768) ? (65535 - p) : p;
    s = 2 * t - 32768;
    return 16'(s);
  endfunction

  // Sample after a given number of accepted ticks since the note was loaded.
  function automatic logic [15:0] model_sample(input int n, input int ticks);
    longint ph;
    if (n == 0) return 16'd0;
    ph = (longint'(ticks) * model_step(n)) % 4194304;
    return model_wave(ph);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic pe, input logic b, input logic g);
    play_enable = pe;
    beat = b;
    generate_next_sample = g;
    @(posedge clk);
    #1;
    beat = 1'b0;
    generate_next_sample = 1'b0;
  endtask

  task automatic load_note(input int n, input int d);
    note_to_load = 6'(n);
    duration_to_load = 6'(d);
    load_new_note = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b0);
    load_new_note = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      note_to_load = 6'($urandom_range(1, 63));
      duration_to_load = 6'($urandom_range(1, 5));
      load_new_note = 1'($urandom_range(0, 1));
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
      n_checks++; if (sample_out !== 16'd0) $display("FAIL reset_sample: got %h want 0000", sample_out); else n_pass++;
      n_checks++; if (new_sample_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", new_sample_ready); else n_pass++;
      n_checks++; if (done_with_note !== 1'b0) $display("FAIL reset_done: got %b want 0", done_with_note); else n_pass++;
    end
    reset = 1'b0;
    load_new_note = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b1);
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL post_reset_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    n_checks++; if (new_sample_ready !== 1'b0) $display("FAIL post_reset_ready: got %b want 0", new_sample_ready); else n_pass++;
    last_sample = 16'd0;
  endtask

  task automatic test_rest_note();
    int beats;
    int done_cnt;
    logic b;
    logic g;
    load_note(0, 3);
    n_checks++; if (dbg_state !== ST_LOAD) $display("FAIL rest_load_state: got %0d want %0d", dbg_state, ST_LOAD); else n_pass++;
    drive_cycle(1'b1, 1'b0, 1'b0);
    beats = 0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 40 && beats < 3; cyc++) begin
      b = (cyc % 10 == 9);
      g = (cyc % 3 == 0);
      drive_cycle(1'b1, b, g);
      if (b) beats++;
      if (done_with_note === 1'b1) done_cnt++;
      n_checks++; if (done_with_note !== (beats == 3)) $display("FAIL rest_done cyc%0d: got %b want %b", cyc, done_with_note, beats == 3); else n_pass++;
      n_checks++; if (sample_out !== 16'd0) $display("FAIL rest_sample cyc%0d: got %h want 0000", cyc, sample_out); else n_pass++;
      n_checks++; if (new_sample_ready !== g) $display("FAIL rest_ready cyc%0d: got %b want %b", cyc, new_sample_ready, g); else n_pass++;
    end
    drive_cycle(1'b1, 1'b0, 1'b0);
    n_checks++; if (done_cnt !== 1) $display("FAIL rest_done_count: got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rest_end_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    n_checks++; if (done_with_note !== 1'b0) $display("FAIL rest_end_done: got %b want 0", done_with_note); else n_pass++;
    last_sample = 16'd0;
  endtask

  task automatic test_sample_path();
    int n;
    int pulses;
    logic [15:0] exp_s;
    for (int r = 0; r < 3; r++) begin
      n = (r == 0) ? 1 : (r == 1) ? 63 : int'($urandom_range(2, 62));
      load_note(n, 2);
      drive_cycle(1'b1, 1'b0, 1'b0);
      pulses = 0;
      for (int k = 1; k <= 5; k++) begin
        for (int gap = int'($urandom_range(0, 2)); gap > 0; gap--) begin
          drive_cycle(1'b1, 1'b0, 1'b0);
          if (new_sample_ready === 1'b1) pulses++;
          n_checks++; if (new_sample_ready !== 1'b0) $display("FAIL sp_gap_ready n%0d: got %b want 0", n, new_sample_ready); else n_pass++;
          n_checks++; if (sample_out !== last_sample) $display("FAIL sp_gap_hold n%0d: got %h want %h", n, sample_out, last_sample); else n_pass++;
        end
        drive_cycle(1'b1, 1'b0, 1'b1);
        if (new_sample_ready === 1'b1) pulses++;
        exp_s = model_sample(n, k);
        last_sample = exp_s;
        n_checks++; if (new_sample_ready !== 1'b1) $display("FAIL sp_tick_ready n%0d k%0d: got %b want 1", n, k, new_sample_ready); else n_pass++;
        n_checks++; if (sample_out !== exp_s) $display("FAIL sp_sample n%0d k%0d: got %h want %h", n, k, sample_out, exp_s); else n_pass++;
      end
      n_checks++; if (pulses !== 5) $display("FAIL sp_pulse_count n%0d: got %0d want 5", n, pulses); else n_pass++;
      drive_cycle(1'b1, 1'b1, 1'b0);
      n_checks++; if (done_with_note !== 1'b0) $display("FAIL sp_beat1_done n%0d: got %b want 0", n, done_with_note); else n_pass++;
      drive_cycle(1'b1, 1'b1, 1'b0);
      n_checks++; if (done_with_note !== 1'b1) $display("FAIL sp_beat2_done n%0d: got %b want 1", n, done_with_note); else n_pass++;
      drive_cycle(1'b1, 1'b0, 1'b0);
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL sp_end_state n%0d: got %0d want %0d", n, dbg_state, ST_IDLE); else n_pass++;
    end
  endtask

  task automatic test_zero_duration();
    load_note(int'($urandom_range(1, 63)), 0);
    n_checks++; if (dbg_state !== ST_LOAD) $display("FAIL zd_state_load: got %0d want %0d", dbg_state, ST_LOAD); else n_pass++;
    n_checks++; if (done_with_note !== 1'b0) $display("FAIL zd_done_early: got %b want 0", done_with_note); else n_pass++;
    drive_cycle(1'b1, 1'b0, 1'b1);
    n_checks++; if (dbg_state !== ST_DONE) $display("FAIL zd_state_done: got %0d want %0d", dbg_state, ST_DONE); else n_pass++;
    n_checks++; if (done_with_note !== 1'b1) $display("FAIL zd_done: got %b want 1", done_with_note); else n_pass++;
    n_checks++; if (new_sample_ready !== 1'b0) $display("FAIL zd_ready1: got %b want 0", new_sample_ready); else n_pass++;
    drive_cycle(1'b1, 1'b0, 1'b1);
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL zd_state_idle: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    n_checks++; if (done_with_note !== 1'b0) $display("FAIL zd_done_after: got %b want 0", done_with_note); else n_pass++;
    n_checks++; if (new_sample_ready !== 1'b0) $display("FAIL zd_ready2: got %b want 0", new_sample_ready); else n_pass++;
    n_checks++; if (sample_out !== last_sample) $display("FAIL zd_hold: got %h want %h", sample_out, last_sample); else n_pass++;
  endtask

  task automatic test_pause();
    int n;
    logic [15:0] exp_s;
    n = int'($urandom_range(40, 63));
    load_note(n, 4);
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b1);
    exp_s = model_sample(n, 1);
    last_sample = exp_s;
    n_checks++; if (sample_out !== exp_s) $display("FAIL pause_pre_sample: got %h want %h", sample_out, exp_s); else n_pass++;
    drive_cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_checks++; if (new_sample_ready !== 1'b0) $display("FAIL pause_ready cyc%0d: got %b want 0", i, new_sample_ready); else n_pass++;
      n_checks++; if (sample_out !== last_sample) $display("FAIL pause_hold cyc%0d: got %h want %h", i, sample_out, last_sample); else n_pass++;
      n_checks++; if (dbg_state !== ST_PLAY) $display("FAIL pause_state cyc%0d: got %0d want %0d", i, dbg_state, ST_PLAY); else n_pass++;
    end
    drive_cycle(1'b1, 1'b0, 1'b1);
    exp_s = model_sample(n, 2);
    last_sample = exp_s;
    n_checks++; if (new_sample_ready !== 1'b1) $display("FAIL pause_resume_ready: got %b want 1", new_sample_ready); else n_pass++;
    n_checks++; if (sample_out !== exp_s) $display("FAIL pause_resume_sample: got %h want %h", sample_out, exp_s); else n_pass++;
    drive_cycle(1'b1, 1'b1, 1'b0);
    n_checks++; if (done_with_note !== 1'b0) $display("FAIL pause_beat3_done: got %b want 0", done_with_note); else n_pass++;
    drive_cycle(1'b1, 1'b1, 1'b0);
    n_checks++; if (done_with_note !== 1'b1) $display("FAIL pause_beat4_done: got %b want 1", done_with_note); else n_pass++;
    drive_cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n1;
    int n2;
    logic [15:0] exp_s;
    n1 = int'($urandom_range(1, 30));
    n2 = int'($urandom_range(31, 63));
    load_note(n1, 1);
    drive_cycle(1'b1, 1'b0, 1'b0);
    // load offered while playing must be ignored
    note_to_load = 6'(n2);
    duration_to_load = 6'd5;
    load_new_note = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b1);
    load_new_note = 1'b0;
    exp_s = model_sample(n1, 1);
    last_sample = exp_s;
    n_checks++; if (dbg_state !== ST_PLAY) $display("FAIL b2b_ignore_state: got %0d want %0d", dbg_state, ST_PLAY); else n_pass++;
    n_checks++; if (sample_out !== exp_s) $display("FAIL b2b_ignore_note: got %h want %h", sample_out, exp_s); else n_pass++;
    drive_cycle(1'b1, 1'b1, 1'b1);
    exp_s = model_sample(n1, 2);
    last_sample = exp_s;
    n_checks++; if (dbg_state !== ST_DONE) $display("FAIL b2b_done_state: got %0d want %0d", dbg_state, ST_DONE); else n_pass++;
    n_checks++; if (done_with_note !== 1'b1) $display("FAIL b2b_done_pulse: got %b want 1", done_with_note); else n_pass++;
    n_checks++; if (sample_out !== exp_s) $display("FAIL b2b_final_sample: got %h want %h", sample_out, exp_s); else n_pass++;
    // load offered in the DONE cycle goes straight to LOAD
    load_note(n2, 2);
    n_checks++; if (dbg_state !== ST_LOAD) $display("FAIL b2b_reload_state: got %0d want %0d", dbg_state, ST_LOAD); else n_pass++;
    n_checks++; if (done_with_note !== 1'b0) $display("FAIL b2b_reload_done: got %b want 0", done_with_note); else n_pass++;
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b1);
    exp_s = model_sample(n2, 1);
    last_sample = exp_s;
    n_checks++; if (sample_out !== exp_s) $display("FAIL b2b_new_note: got %h want %h", sample_out, exp_s); else n_pass++;
    drive_cycle(1'b1, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0);
    n_checks++; if (done_with_note !== 1'b1) $display("FAIL b2b_second_done: got %b want 1", done_with_note); else n_pass++;
    drive_cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_note();
    int n;
    logic [15:0] exp_s;
    n = int'($urandom_range(1, 63));
    load_note(n, 5);
    drive_cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive_cycle(1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    load_new_note = 1'b1;
    drive_cycle(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    load_new_note = 1'b0;
    last_sample = 16'd0;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rmid_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    n_checks++; if (sample_out !== 16'd0) $display("FAIL rmid_sample: got %h want 0000", sample_out); else n_pass++;
    n_checks++; if (new_sample_ready !== 1'b0) $display("FAIL rmid_ready: got %b want 0", new_sample_ready); else n_pass++;
    n_checks++; if (done_with_note !== 1'b0) $display("FAIL rmid_done: got %b want 0", done_with_note); else n_pass++;
    drive_cycle(1'b1, 1'b1, 1'b1);
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rmid_idle: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    n_checks++; if (done_with_note !== 1'b0) $display("FAIL rmid_no_done: got %b want 0", done_with_note); else n_pass++;
    load_note(n, 1);
    n_checks++; if (dbg_state !== ST_LOAD) $display("FAIL rmid_reload: got %0d want %0d", dbg_state, ST_LOAD); else n_pass++;
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b1);
    exp_s = model_sample(n, 1);
    last_sample = exp_s;
    n_checks++; if (sample_out !== exp_s) $display("FAIL rmid_phase_cleared: got %h want %h", sample_out, exp_s); else n_pass++;
    n_checks++; if (done_with_note !== 1'b1) $display("FAIL rmid_final_done: got %b want 1", done_with_note); else n_pass++;
    drive_cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random_notes();
    int n;
    int d;
    int left;
    int ticks;
    int cyc;
    logic pe;
    logic b;
    logic g;
    for (int r = 0; r < 10; r++) begin
      for (int gap = int'($urandom_range(0, 3)); gap > 0; gap--) begin
        drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        n_checks++; if (new_sample_ready !== 1'b0) $display("FAIL rnd_idle_ready r%0d: got %b want 0", r, new_sample_ready); else n_pass++;
        n_checks++; if (sample_out !== last_sample) $display("FAIL rnd_idle_hold r%0d: got %h want %h", r, sample_out, last_sample); else n_pass++;
      end
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      d = int'($urandom_range(0, 4));
      load_note(n, d);
      n_checks++; if (dbg_state !== ST_LOAD) $display("FAIL rnd_load r%0d: got %0d want %0d", r, dbg_state, ST_LOAD); else n_pass++;
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_checks++; if (new_sample_ready !== 1'b0) $display("FAIL rnd_load_ready r%0d: got %b want 0", r, new_sample_ready); else n_pass++;
      if (d == 0) begin
        n_checks++; if (done_with_note !== 1'b1) $display("FAIL rnd_zero_done r%0d: got %b want 1", r, done_with_note); else n_pass++;
      end else begin
        left = d;
        ticks = 0;
        cyc = 0;
        while (left > 0 && cyc < 400) begin
          pe = ($urandom_range(0, 99) < 85);
          b = ($urandom_range(0, 3) == 0);
          g = ($urandom_range(0, 9) < 4);
          drive_cycle(pe, b, g);
          if (pe && g) begin
            ticks++;
            last_sample = model_sample(n, ticks);
          end
          if (pe && b) left--;
          n_checks++; if (new_sample_ready !== (pe && g)) $display("FAIL rnd_ready r%0d cyc%0d: got %b want %b", r, cyc, new_sample_ready, pe && g); else n_pass++;
          n_checks++; if (sample_out !== last_sample) $display("FAIL rnd_sample r%0d cyc%0d n%0d: got %h want %h", r, cyc, n, sample_out, last_sample); else n_pass++;
          n_checks++; if (done_with_note !== (left == 0)) $display("FAIL rnd_done r%0d cyc%0d: got %b want %b", r, cyc, done_with_note, left == 0); else n_pass++;
          cyc++;
        end
        if (left > 0) begin
          n_checks++;
          $display("FAIL rnd_timeout r%0d: beats left %0d want 0", r, left);
        end
      end
      drive_cycle(1'b1, 1'b0, 1'b0);
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rnd_end_state r%0d: got %0d want %0d", r, dbg_state, ST_IDLE); else n_pass++;
      n_checks++; if (done_with_note !== 1'b0) $display("FAIL rnd_end_done r%0d: got %b want 0", r, done_with_note); else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    play_enable = 1'b0;
    note_to_load = 6'd0;
    duration_to_load = 6'd0;
    load_new_note = 1'b0;
    beat = 1'b0;
    generate_next_sample = 1'b0;
    last_sample = 16'd0;

    test_reset();
    test_rest_note();
    test_sample_path();
    test_zero_duration();
    test_pause();
    test_back_to_back();
    test_reset_mid_note();
    test_random_notes();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 Parameter: PHASE_W, default 22, phase accumulator width (10.12 fixed point).
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
REQ-004 Port: play_enable  input  1  high = playback running; low = freeze (pause).
REQ-005 Port: note_to_load  input  6  note index from song_reader; 0 = rest.
REQ-006 Port: duration_to_load  input  6  note length in beats.
REQ-007 Port: load_new_note  input  1  one-cycle pulse from song_reader: note/duration are valid.
REQ-008 Port: beat  input  1  one-cycle tick, 48 per second.
REQ-009 Port: generate_next_sample  input  1  one-cycle sample-rate tick from the codec side.
REQ-010 Port: done_with_note  output  1  one-cycle pulse to song_reader (its note_done).
REQ-011 Port: sample_out  output  16  signed sample, two's complement.
REQ-012 Port: new_sample_ready  output  1  one-cycle pulse: sample_out updated this cycle.

Function
REQ-013 The block SHALL implement states IDLE, LOAD, PLAYING, DONE, held in a dffre-style state register.
REQ-014 IDLE SHALL move to LOAD on load_new_note, latching note_to_load and duration_to_load; otherwise stay.
REQ-015 LOAD SHALL last exactly one cycle: the step size for the latched note is read from frequency_rom (one-cycle registered read) and registered; the beat counter is loaded with the latched duration; phase is cleared to 0.
REQ-016 LOAD SHALL go to DONE if the latched duration is 0, else to PLAYING.
REQ-017 In PLAYING, beat AND play_enable SHALL decrement the beat counter by 1; when the counter is 1 and decrements, the next state SHALL be DONE.
REQ-018 DONE SHALL last one cycle with done_with_note = 1, then go to IDLE; done_with_note SHALL be 0 in every other state.
REQ-019 load_new_note SHALL be accepted in IDLE and DONE (DONE goes directly to LOAD, done_with_note still pulses); it SHALL be ignored in LOAD and PLAYING.
REQ-020 In PLAYING, generate_next_sample AND play_enable SHALL advance phase by step, modulo 2^PHASE_W; for note 0 the phase SHALL not advance.
REQ-021 Sample path: one cycle after an accepted generate_next_sample, sample_out SHALL update and new_sample_ready SHALL pulse high for one cycle.
REQ-022 Waveform: p = phase[PHASE_W-1 -: 16]; t = p[15] ? ~p[14:0] : p[14:0]; sample_out = {t,1'b0} - 32768 (range -32768..32766); for note 0, sample_out SHALL be 0.
REQ-023 generate_next_sample outside PLAYING SHALL produce no new_sample_ready pulse; sample_out SHALL hold its last value.
REQ-024 play_enable low SHALL freeze beat counter, phase, sample_out and state (except IDLE accepting loads), and SHALL suppress new_sample_ready.
REQ-025 beat and generate_next_sample in the same cycle SHALL both take effect; the final beat and a sample tick coinciding SHALL still emit that sample.
REQ-026 Phase wrap SHALL be silent modular overflow; no flag is produced.

Reset
REQ-027 reset SHALL force: state IDLE, phase 0, step 0, beat counter 0, latched note/duration 0, sample_out 0, new_sample_ready 0, done_with_note 0.
REQ-028 reset SHALL take priority over every other input, including mid-note; the next cycle SHALL behave as IDLE after reset.

Verification
REQ-029 Load note 0, duration 3, play_enable=1, beats every 10 cycles -> done_with_note pulses once, one cycle after the cycle holding the 3rd beat; sample_out stays 0 throughout.
REQ-030 Load note n, duration 2, step S = frequency_rom[n], 5 sample ticks -> 5 new_sample_ready pulses, each one cycle after its tick; final phase = 5*S mod 2^22; sample_out matches REQ-022.
REQ-031 Load duration 0 -> IDLE, LOAD, DONE; done_with_note high exactly 2 cycles after load_new_note; no samples emitted.
REQ-032 In PLAYING with counter 2, drop play_enable for 50 cycles with beats and sample ticks -> counter, phase, sample_out unchanged, no pulses; re-enable -> note finishes after 2 more beats.
REQ-033 load_new_note in the DONE cycle -> done_with_note still pulses, next state LOAD, new note latched; load_new_note during PLAYING -> ignored, latched note unchanged.
REQ-034 Assert reset mid-PLAYING with phase nonzero -> next cycle all outputs 0, state IDLE; no done_with_note pulse.
